// File: rtl/cpu_pkg.sv
// Shared RV32 fetch-side definitions: opcodes used by predecode and
// branch/jump immediate extraction (results include the implicit zero LSB).
package cpu_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // B-type: hi = instr[31:25], lo = instr[11:7]
  function automatic logic [12:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
    return {hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

  // J-type: u = instr[31:12]
  function automatic logic [20:0] imm_j(input logic [19:0] u);
    return {u[19], u[7:0], u[8], u[18:9], 1'b0};
  endfunction

endpackage

// File: rtl/cpu_fetch_queue.sv
// Power-of-two FIFO with synchronous flush; head is read straight from storage.
// Flush overrides push and pop in the same cycle; pop on empty is ignored.
module cpu_fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !flush;
  assign do_pop    = pop && !flush && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The producer's issue rule guarantees a free slot for every response.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && count == DEPTH_C));

endmodule

// File: rtl/cpu_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight, predecodes B/JAL
// responses against the predictor and queues them; redirects flush and squash.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              QUEUE_DEPTH  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] bp_addr,
  input  logic            bp_taken,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_pred_taken,
  output logic [XLEN-1:0] out_pred_target
);

  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam int EW = 32 + XLEN + 1 + XLEN;

  logic            outstanding;
  logic            stale;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;

  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  logic [CW-1:0]   q_count;
  logic [EW-1:0]   q_head;

  logic [6:0]      opcode;
  logic [12:0]     ib;
  logic [20:0]     ij;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target;
  logic            pred_taken;
  logic [XLEN-1:0] next_pc;

  // Gated by rst_n so no request is presented while reset is held.
  assign imem_req_valid = rst_n && !outstanding && (q_count < DEPTH_C) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign bp_addr        = req_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && outstanding;
  assign push     = rsp_fire && !stale && !redirect_valid;
  assign pop      = out_valid && out_ready;

  always_comb begin
    opcode     = imem_rsp_data[6:0];
    ib         = imm_b(imem_rsp_data[31:25], imem_rsp_data[11:7]);
    ij         = imm_j(imem_rsp_data[31:12]);
    seq_pc     = req_pc + XLEN'(4);
    target     = seq_pc;
    pred_taken = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        target     = req_pc + {{(XLEN-13){ib[12]}}, ib};
        pred_taken = bp_taken;
      end
      OP_JAL: begin
        target     = req_pc + {{(XLEN-21){ij[20]}}, ij};
        pred_taken = 1'b1;
      end
      OP_JALR:  pred_taken = 1'b0;
      default:  pred_taken = 1'b0;
    endcase
    next_pc = pred_taken ? target : seq_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      req_pc      <= RESET_VECTOR;
      outstanding <= 1'b0;
      stale       <= 1'b0;
    end else begin
      if (req_fire) begin
        outstanding <= 1'b1;
        req_pc      <= pc;
      end else if (rsp_fire) begin
        outstanding <= 1'b0;
      end

      // A squashed request still owes us one response, which must be dropped.
      if (redirect_valid)
        stale <= outstanding && !imem_rsp_valid;
      else if (rsp_fire && stale)
        stale <= 1'b0;

      if (redirect_valid)
        pc <= redirect_pc;
      else if (push)
        pc <= next_pc;
    end
  end

  cpu_fetch_queue #(
    .WIDTH (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rsp_data, req_pc, pred_taken, next_pc}),
    .pop       (pop),
    .head_data (q_head),
    .count     (q_count)
  );

  assign out_valid = (q_count != '0);
  assign {out_instr, out_pc, out_pred_taken, out_pred_target} = q_head;

endmodule
